// File: rtl/data_mem_wbuf.sv
// Data-memory stage for the single-cycle core: a 2^ADDR_W x DATA_W word array
// fronted by a posted-write buffer with same-cycle load forwarding.
module data_mem_wbuf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       CEN,
    input  logic                       WEN,
    input  logic                       OEN,
    input  logic [ADDR_W-1:0]          A,
    input  logic [DATA_W-1:0]          Data2Mem,
    output logic [DATA_W-1:0]          ReadDataMem,
    output logic                       wb_empty,
    output logic [$clog2(DEPTH):0]     wb_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  r_vld;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_mem  [0:(1<<ADDR_W)-1];

    logic              w_write;
    logic              w_read;
    logic              w_hit;
    logic [PTR_W-1:0]  w_hit_idx;
    logic              w_drain;
    logic              w_enq;
    logic              w_head_coal;
    logic [ADDR_W-1:0] w_drain_addr;
    logic [DATA_W-1:0] w_drain_data;

    // A store with WEN and OEN both low is a write, never a read.
    assign w_write = ~CEN & ~WEN;
    assign w_read  = ~CEN & ~OEN & WEN;

    // Coalescing keeps addresses unique, so at most one entry can match.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == A)) begin
                w_hit     = 1'b1;
                w_hit_idx = PTR_W'(i);
            end
        end
    end

    assign w_drain      = ~w_read & (r_count != '0);
    assign w_enq        = w_write & ~w_hit;
    assign w_head_coal  = w_write & w_hit & (w_hit_idx == r_head);
    assign w_drain_addr = r_addr[r_head];
    // A store coalescing into the draining head goes straight to the array.
    assign w_drain_data = w_head_coal ? Data2Mem : r_data[r_head];

    always_comb begin
        ReadDataMem = '0;
        if (w_read) begin
            ReadDataMem = w_hit ? r_data[w_hit_idx] : r_mem[A];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_drain) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            if (w_write && w_hit) begin
                r_data[w_hit_idx] <= Data2Mem;
            end
            // When full, tail equals head; the valid set here overrides the drain clear.
            if (w_enq) begin
                r_vld[r_tail]  <= 1'b1;
                r_addr[r_tail] <= A;
                r_data[r_tail] <= Data2Mem;
                r_tail         <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_drain);
        end
    end

    always_ff @(posedge clk) begin
        if (w_drain) begin
            r_mem[w_drain_addr] <= w_drain_data;
        end
    end

    assign wb_empty = (r_count == '0);
    assign wb_count = r_count;

endmodule

// File: tb/tb_data_mem_wbuf.sv
// Bench for data_mem_wbuf: hand-derived vector table, an async-reset sequence,
// and a randomized phase against a behavioural posted-write-buffer model.
module tb_data_mem_wbuf;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              CEN = 1'b1;
    logic              WEN = 1'b1;
    logic              OEN = 1'b1;
    logic [ADDR_W-1:0] A = '0;
    logic [DATA_W-1:0] Data2Mem = '0;
    logic [DATA_W-1:0] ReadDataMem;
    logic              wb_empty;
    logic [CNT_W-1:0]  wb_count;

    always #5 clk = ~clk;

    data_mem_wbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .CEN        (CEN),
        .WEN        (WEN),
        .OEN        (OEN),
        .A          (A),
        .Data2Mem   (Data2Mem),
        .ReadDataMem(ReadDataMem),
        .wb_empty   (wb_empty),
        .wb_count   (wb_count)
    );

    typedef struct {
        logic [DATA_W-1:0] rd;
        int                cnt;
        string             tag;
    } exp_t;

    typedef struct {
        logic              cen;
        logic              wen;
        logic              oen;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] rd;
        int                cnt;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    exp_t sb[$];
    vec_t tbl[$];
    ent_t pend[$];
    logic [DATA_W-1:0] m_arr [128];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, " rd"},    ReadDataMem,      e.rd);
            check({e.tag, " cnt"},   32'(wb_count),    32'(e.cnt));
            check({e.tag, " empty"}, 32'(wb_empty),    32'(e.cnt == 0));
        end
    end

    function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
        for (int i = 0; i < pend.size(); i++)
            if (pend[i].a == a) return pend[i].d;
        return m_arr[a];
    endfunction

    function automatic void m_step(input logic cen, input logic wen, input logic oen,
                                   input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit   wr, rd, drain;
        int   hit;
        ent_t ne;
        wr    = !cen && !wen;
        rd    = !cen && !oen && wen;
        drain = !rd && (pend.size() > 0);
        hit   = -1;
        for (int i = 0; i < pend.size(); i++)
            if (pend[i].a == a) hit = i;
        if (wr && hit >= 0) pend[hit].d = d;
        if (drain) begin
            m_arr[pend[0].a] = pend[0].d;
            void'(pend.pop_front());
        end
        if (wr && hit < 0) begin
            ne.a = a;
            ne.d = d;
            pend.push_back(ne);
        end
    endfunction

    task automatic drive(input logic cen, input logic wen, input logic oen,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [DATA_W-1:0] exp_rd, input int exp_cnt, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        CEN = cen; WEN = wen; OEN = oen; A = a; Data2Mem = d;
        e.rd  = exp_rd;
        e.cnt = exp_cnt;
        e.tag = tag;
        sb.push_back(e);
        m_step(cen, wen, oen, a, d);
    endtask

    task automatic model_drive(input logic cen, input logic wen, input logic oen,
                               input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input string tag);
        logic [DATA_W-1:0] er;
        er = (!cen && !oen && wen) ? m_read(a) : '0;
        drive(cen, wen, oen, a, d, er, pend.size(), tag);
    endtask

    task automatic add_v(input logic cen, input logic wen, input logic oen,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [DATA_W-1:0] rd, input int cnt);
        vec_t v;
        v.cen = cen; v.wen = wen; v.oen = oen; v.a = a; v.d = d; v.rd = rd; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // store: cen=0 wen=0 oen=1; load: cen=0 wen=1 oen=0; idle: cen=1
        add_v(0,0,1, 7'd5, 32'hDEAD_BEEF, 32'h0, 0);
        add_v(0,1,0, 7'd5, 32'h0, 32'hDEAD_BEEF, 1);
        add_v(1,1,1, 7'd0, 32'h0, 32'h0, 1);
        add_v(0,1,0, 7'd5, 32'h0, 32'hDEAD_BEEF, 0);
        add_v(0,0,1, 7'd1, 32'h1111_0001, 32'h0, 0);
        add_v(0,0,1, 7'd2, 32'h2222_0002, 32'h0, 1);
        add_v(0,0,1, 7'd3, 32'h3333_0003, 32'h0, 1);
        add_v(0,0,1, 7'd4, 32'h4444_0004, 32'h0, 1);
        add_v(1,1,1, 7'd0, 32'h0, 32'h0, 1);
        add_v(1,1,1, 7'd0, 32'h0, 32'h0, 0);
        add_v(0,1,0, 7'd1, 32'h0, 32'h1111_0001, 0);
        add_v(0,1,0, 7'd2, 32'h0, 32'h2222_0002, 0);
        add_v(0,1,0, 7'd3, 32'h0, 32'h3333_0003, 0);
        add_v(0,1,0, 7'd4, 32'h0, 32'h4444_0004, 0);
        add_v(0,0,1, 7'd9, 32'h9999_0009, 32'h0, 0);
        add_v(1,1,1, 7'd0, 32'h0, 32'h0, 1);
        add_v(0,0,1, 7'd1, 32'hA000_0001, 32'h0, 0);
        add_v(0,1,0, 7'd9, 32'h0, 32'h9999_0009, 1);
        add_v(0,0,1, 7'd2, 32'hA000_0002, 32'h0, 1);
        add_v(0,1,0, 7'd9, 32'h0, 32'h9999_0009, 1);
        add_v(0,0,1, 7'd3, 32'hA000_0003, 32'h0, 1);
        add_v(0,1,0, 7'd9, 32'h0, 32'h9999_0009, 1);
        add_v(0,0,1, 7'd4, 32'hA000_0004, 32'h0, 1);
        add_v(0,1,0, 7'd9, 32'h0, 32'h9999_0009, 1);
        add_v(0,0,1, 7'd6, 32'hA000_0006, 32'h0, 1);
        add_v(0,1,0, 7'd1, 32'h0, 32'hA000_0001, 1);
        add_v(0,1,0, 7'd2, 32'h0, 32'hA000_0002, 1);
        add_v(0,1,0, 7'd3, 32'h0, 32'hA000_0003, 1);
        add_v(0,1,0, 7'd4, 32'h0, 32'hA000_0004, 1);
        add_v(0,1,0, 7'd5, 32'h0, 32'hDEAD_BEEF, 1);
        add_v(0,1,0, 7'd6, 32'h0, 32'hA000_0006, 1);
        add_v(1,1,1, 7'd0, 32'h0, 32'h0, 1);
        add_v(0,0,1, 7'd7, 32'h0000_0001, 32'h0, 0);
        add_v(0,1,0, 7'd7, 32'h0, 32'h0000_0001, 1);
        add_v(0,0,1, 7'd7, 32'h0000_0002, 32'h0, 1);
        add_v(0,1,0, 7'd7, 32'h0, 32'h0000_0002, 0);
        add_v(1,1,1, 7'd0, 32'h0, 32'h0, 0);
        add_v(0,1,0, 7'd7, 32'h0, 32'h0000_0002, 0);
        add_v(0,0,1, 7'd8, 32'h0000_0088, 32'h0, 0);
        add_v(1,0,0, 7'd8, 32'hFFFF_FFFF, 32'h0, 1);
        add_v(0,1,0, 7'd8, 32'h0, 32'h0000_0088, 0);
        add_v(1,0,0, 7'd8, 32'hFFFF_FFFF, 32'h0, 0);
        add_v(0,1,0, 7'd8, 32'h0, 32'h0000_0088, 0);
        add_v(0,0,0, 7'd8, 32'h8888_0000, 32'h0, 0);
        add_v(0,1,0, 7'd8, 32'h0, 32'h8888_0000, 1);
        add_v(0,1,1, 7'd8, 32'h0, 32'h0, 1);
        add_v(0,1,0, 7'd8, 32'h0, 32'h8888_0000, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset empty", 32'(wb_empty), 32'd1);
        check("reset count", 32'(wb_count), 32'd0);
        check("reset rd",    ReadDataMem,   32'd0);
        rst_n = 1'b1;

        foreach (tbl[i])
            drive(tbl[i].cen, tbl[i].wen, tbl[i].oen, tbl[i].a, tbl[i].d,
                  tbl[i].rd, tbl[i].cnt, $sformatf("vec%0d", i));

        // Async reset with a store still buffered: the store must be lost.
        drive(0,0,1, 7'd10, 32'h0000_0010, 32'h0, 0, "rst_pre_st");
        drive(1,1,1, 7'd0,  32'h0,         32'h0, 1, "rst_pre_idle");
        drive(0,0,1, 7'd10, 32'h0000_0020, 32'h0, 0, "rst_buf_st");
        @(posedge clk);
        #1;
        CEN = 1'b1; WEN = 1'b1; OEN = 1'b1;
        check("rst buffered count", 32'(wb_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst async empty", 32'(wb_empty), 32'd1);
        check("rst async count", 32'(wb_count), 32'd0);
        pend.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0,1,0, 7'd10, 32'h0, 32'h0000_0010, 0, "rst_post_ld");
        drive(1,1,1, 7'd0,  32'h0, 32'h0,         0, "rst_post_idle");
        drive(0,1,0, 7'd10, 32'h0, 32'h0000_0010, 0, "rst_post_ld2");

        for (int a = 0; a < 16; a++) begin
            model_drive(0,0,1, 7'(a), $urandom, $sformatf("init_st%0d", a));
            model_drive(1,1,1, 7'd0, 32'h0, $sformatf("init_idle%0d", a));
        end

        for (int n = 0; n < 300; n++) begin
            int r;
            logic [ADDR_W-1:0] ra;
            r  = $urandom_range(0, 9);
            ra = 7'($urandom_range(0, 15));
            if (r < 4)      model_drive(0, 0, 1'($urandom_range(0, 1)), ra, $urandom, $sformatf("rnd%0d st", n));
            else if (r < 8) model_drive(0, 1, 0, ra, 32'h0, $sformatf("rnd%0d ld", n));
            else if (r == 8) model_drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom, $sformatf("rnd%0d idle", n));
            else            model_drive(0, 1, 1, ra, 32'h0, $sformatf("rnd%0d nop", n));
        end
        for (int a = 0; a < 16; a++)
            model_drive(0,1,0, 7'(a), 32'h0, $sformatf("final_ld%0d", a));

        k = 0;
        while (sb.size() > 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
